// File: rtl/fp_addsub_unit.sv
// rtl/fp_addsub_unit.sv - three-stage pipelined single-precision FP add/subtract unit
//
// Purpose: accepts one FADD/FSUB per cycle from the FP issue port and broadcasts
// the truncated result, with its tag and destination, exactly three cycles later.
// Stages: E1 align (registered from the issue inputs), E2 add/subtract,
// E3 normalise/pack (the output registers).
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high; drops every in-flight op
//   we_i       - issue valid
//   op_i       - 0 = FADD (val1+val2), 1 = FSUB (val1-val2)
//   dst_i      - architectural destination register
//   dst_tag_i  - rename tag of the result
//   val1_i     - operand A
//   val2_i     - operand B
//   we_FP      - result broadcast valid (one cycle per accepted op)
//   tag_FP     - tag of broadcast result (holds while we_FP=0)
//   dst_FP     - destination of broadcast result (holds while we_FP=0)
//   val_FP     - result value (holds while we_FP=0)
//   inflight   - number of valid ops in E1..E2
module fp_addsub_unit #(
   parameter int TAG_W  = 5,
   parameter int REG_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic              op_i,
   input  logic [REG_W-1:0]  dst_i,
   input  logic [TAG_W-1:0]  dst_tag_i,
   input  logic [DATA_W-1:0] val1_i,
   input  logic [DATA_W-1:0] val2_i,
   output logic              we_FP,
   output logic [TAG_W-1:0]  tag_FP,
   output logic [REG_W-1:0]  dst_FP,
   output logic [DATA_W-1:0] val_FP,
   output logic [1:0]        inflight
);

   // ---------------------------------------------------------------
   // E1 next state: decode, special detection, operand order, align
   // ---------------------------------------------------------------
   logic [7:0]        a_exp, b_exp;
   logic [22:0]       a_frac, b_frac;
   logic              b_sign;
   logic              swap;
   logic [7:0]        x_exp, y_exp, d;
   logic [23:0]       x_mant, y_mant;
   logic              x_sign, y_sign;
   logic              e1_spec_d;
   logic [DATA_W-1:0] e1_spec_val_d;
   logic [23:0]       e1_my_d;

   always_comb begin
      a_exp  = val1_i[30:23];
      b_exp  = val2_i[30:23];
      // Denormals are flushed, so a zero exponent also discards the fraction.
      a_frac = (a_exp == 8'd0) ? 23'd0 : val1_i[22:0];
      b_frac = (b_exp == 8'd0) ? 23'd0 : val2_i[22:0];
      b_sign = val2_i[31] ^ op_i;

      // Strictly-greater test keeps A as X on a magnitude tie.
      swap   = {b_exp, b_frac} > {a_exp, a_frac};
      x_exp  = swap ? b_exp : a_exp;
      y_exp  = swap ? a_exp : b_exp;
      x_sign = swap ? b_sign : val1_i[31];
      y_sign = swap ? val1_i[31] : b_sign;
      x_mant = swap ? {b_exp != 8'd0, b_frac} : {a_exp != 8'd0, a_frac};
      y_mant = swap ? {a_exp != 8'd0, a_frac} : {b_exp != 8'd0, b_frac};

      d       = x_exp - y_exp;
      e1_my_d = (d >= 8'd24) ? 24'd0 : (y_mant >> d);

      // Inf/NaN operands bypass the datapath; A takes precedence over B.
      e1_spec_d     = 1'b0;
      e1_spec_val_d = '0;
      if (a_exp == 8'hFF) begin
         e1_spec_d     = 1'b1;
         e1_spec_val_d = val1_i;
      end else if (b_exp == 8'hFF) begin
         e1_spec_d     = 1'b1;
         e1_spec_val_d = {b_sign, val2_i[30:0]};
      end
   end

   logic              e1_valid_q, e1_spec_q, e1_sign_q, e1_sub_q;
   logic [TAG_W-1:0]  e1_tag_q;
   logic [REG_W-1:0]  e1_dst_q;
   logic [DATA_W-1:0] e1_spec_val_q;
   logic [7:0]        e1_exp_q;
   logic [23:0]       e1_mx_q, e1_my_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         e1_valid_q    <= 1'b0;
         e1_spec_q     <= 1'b0;
         e1_sign_q     <= 1'b0;
         e1_sub_q      <= 1'b0;
         e1_tag_q      <= '0;
         e1_dst_q      <= '0;
         e1_spec_val_q <= '0;
         e1_exp_q      <= '0;
         e1_mx_q       <= '0;
         e1_my_q       <= '0;
      end else begin
         e1_valid_q    <= we_i;
         e1_spec_q     <= e1_spec_d;
         e1_sign_q     <= x_sign;
         e1_sub_q      <= x_sign ^ y_sign;
         e1_tag_q      <= dst_tag_i;
         e1_dst_q      <= dst_i;
         e1_spec_val_q <= e1_spec_val_d;
         e1_exp_q      <= x_exp;
         e1_mx_q       <= x_mant;
         e1_my_q       <= e1_my_d;
      end
   end

   // ---------------------------------------------------------------
   // E2: magnitude add/subtract (X >= Y, so the difference is never negative)
   // ---------------------------------------------------------------
   logic [24:0] e2_m_d;

   always_comb begin
      if (e1_sub_q) e2_m_d = {1'b0, e1_mx_q} - {1'b0, e1_my_q};
      else          e2_m_d = {1'b0, e1_mx_q} + {1'b0, e1_my_q};
   end

   logic              e2_valid_q, e2_spec_q, e2_sign_q;
   logic [TAG_W-1:0]  e2_tag_q;
   logic [REG_W-1:0]  e2_dst_q;
   logic [DATA_W-1:0] e2_spec_val_q;
   logic [7:0]        e2_exp_q;
   logic [24:0]       e2_m_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         e2_valid_q    <= 1'b0;
         e2_spec_q     <= 1'b0;
         e2_sign_q     <= 1'b0;
         e2_tag_q      <= '0;
         e2_dst_q      <= '0;
         e2_spec_val_q <= '0;
         e2_exp_q      <= '0;
         e2_m_q        <= '0;
      end else begin
         e2_valid_q    <= e1_valid_q;
         e2_spec_q     <= e1_spec_q;
         e2_sign_q     <= e1_sign_q;
         e2_tag_q      <= e1_tag_q;
         e2_dst_q      <= e1_dst_q;
         e2_spec_val_q <= e1_spec_val_q;
         e2_exp_q      <= e1_exp_q;
         e2_m_q        <= e2_m_d;
      end
   end

   // ---------------------------------------------------------------
   // E3: normalise, overflow/underflow, pack
   // ---------------------------------------------------------------
   function automatic logic [4:0] lzc24(input logic [23:0] v);
      lzc24 = 5'd24;
      // Ascending scan: the highest set bit is the last to write the count.
      for (int i = 0; i < 24; i++) begin
         if (v[i]) lzc24 = 5'(23 - i);
      end
   endfunction

   logic [4:0]        lz;
   logic signed [9:0] exp_n;
   logic [23:0]       mant_n;
   logic [DATA_W-1:0] val_d;

   always_comb begin
      lz     = lzc24(e2_m_q[23:0]);
      exp_n  = '0;
      mant_n = '0;
      val_d  = '0;
      if (e2_m_q[24]) begin
         exp_n  = $signed({2'b00, e2_exp_q}) + 10'sd1;
         mant_n = e2_m_q[24:1];
      end else begin
         exp_n  = $signed({2'b00, e2_exp_q}) - $signed({5'd0, lz});
         mant_n = e2_m_q[23:0] << lz;
      end

      if (e2_spec_q)                val_d = e2_spec_val_q;
      else if (e2_m_q == 25'd0)     val_d = '0;
      else if (exp_n >= 10'sd255)   val_d = {e2_sign_q, 8'hFF, 23'd0};
      else if (exp_n <= 10'sd0)     val_d = {e2_sign_q, 31'd0};
      else                          val_d = {e2_sign_q, exp_n[7:0], mant_n[22:0]};
   end

   logic              we_q;
   logic [TAG_W-1:0]  tag_q;
   logic [REG_W-1:0]  dst_q;
   logic [DATA_W-1:0] val_q;

   // Payload registers only load on a valid op so they hold across bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q  <= 1'b0;
         tag_q <= '0;
         dst_q <= '0;
         val_q <= '0;
      end else begin
         we_q <= e2_valid_q;
         if (e2_valid_q) begin
            tag_q <= e2_tag_q;
            dst_q <= e2_dst_q;
            val_q <= val_d;
         end
      end
   end

   assign we_FP    = we_q;
   assign tag_FP   = tag_q;
   assign dst_FP   = dst_q;
   assign val_FP   = val_q;
   assign inflight = {1'b0, e1_valid_q} + {1'b0, e2_valid_q};

endmodule

// File: doc/fp_addsub_unit.md
Name: fp_addsub_unit

Overview:
- Fully pipelined single-precision FP add/subtract execution unit for the out-of-order core's FP lane.
- Sits at the consumer end of the FP reservation station issue port (we_i/op_i/dst_i/dst_tag_i/val1_i/val2_i).
- Produces the FP result broadcast (we_FP/tag_FP/val_FP) that reservation stations snoop and the register/ROB write-back consumes.
- Accepts one operation every cycle with no backpressure; fixed 3-cycle latency.

Parameters:
- TAG_W, 5, width of the rename tag (dst_tag_i, tag_FP)
- REG_W, 5, width of the architectural destination register index
- DATA_W, 32, operand/result width; IEEE-754 single layout only (fixed, not generic)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- we_i  input  1  issue valid; operation accepted on every rising edge where high
- op_i  input  1  0 = FADD (val1+val2), 1 = FSUB (val1-val2)
- dst_i  input  REG_W  architectural destination register
- dst_tag_i  input  TAG_W  rename tag of the result
- val1_i  input  32  operand A
- val2_i  input  32  operand B
- we_FP  output  1  result broadcast valid, one cycle per accepted op
- tag_FP  output  TAG_W  tag of broadcast result
- dst_FP  output  REG_W  destination register of broadcast result
- val_FP  output  32  result value
- inflight  output  2  number of valid ops in stages E1..E2 (debug/perf)

Behaviour:
- Reset: all stage valid bits 0; we_FP=0, tag_FP=0, dst_FP=0, val_FP=0, inflight=0. Reset asserted mid-operation discards every in-flight op; no broadcast for them.
- Latency: we_i high in cycle c -> we_FP high exactly in cycle c+3, with that op's tag/dst/result. Three register stages E1, E2, E3(output). Back-to-back issues produce back-to-back broadcasts, in order.
- Bubbles: we_i=0 propagates a bubble; we_FP=0 that cycle. tag_FP/dst_FP/val_FP hold their last values when we_FP=0 (only the valid bit clears).
- Operand decode: exponent 0 -> operand is signed zero (denormals flushed). For FSUB, B's sign bit inverted before further processing.
- Special case: exponent 255 on A -> result = A's pattern (sign-adjusted none); else exponent 255 on B -> result = effective B (with FSUB sign flip). NaN not distinguished from Inf.
- E1 (align): order operands so X has larger magnitude by {exp,frac} compare (tie -> X=A). Mantissas 24-bit with hidden 1 (0 if zero operand). d = expX-expY; My >>= d, shifted-out bits discarded (no guard/round/sticky); d>=24 -> My=0.
- E2 (add): signs equal -> M = Mx+My (25 bits); else M = Mx-My (never negative). Sign = signX. Exponent carried = expX.
- E3 (normalise/pack): M==0 -> +0 (0x00000000). M[24]=1 -> M>>=1 (truncate), exp+1. Else shift left by leading-zero count of M[23:0] until M[23]=1, exp-=lz.
- Overflow: resulting exp>=255 -> signed infinity (exp 255, frac 0).
- Underflow: resulting exp<=0 -> signed zero (flush).
- Rounding: truncation everywhere (round toward zero per stage as above); the bench model must implement identical staged truncation.
- inflight = valid(E1)+valid(E2); updated each edge.
- No stall output; upstream issues freely every cycle. we_i with X/garbage operands still yields exactly one broadcast.

Test Plan:
- Reset, then we_i=1, op=0, A=0x3F800000, B=0x40000000, tag=7, dst=3 -> cycle c+3: we_FP=1, tag_FP=7, dst_FP=3, val_FP=0x40400000; we_FP=0 in c+4.
- FSUB 0x40400000 - 0x3F800000 -> 0x40000000; FSUB 0x3FC00000 - 0x3FC00000 -> 0x00000000.
- Four consecutive issues (tags 1,2,3,4; 1.0+1.0, 2.0+2.0, 1.0+2^-30 i.e. 0x30800000, 0x7F7FFFFF+0x7F7FFFFF) -> broadcasts in cycles c+3..c+6, in order: 0x40000000, 0x40800000, 0x3F800000, 0x7F800000; inflight=2 during steady state.
- Denormal/zero: A=0x00000001, B=0x3F800000, FADD -> 0x3F800000; underflow 0x00800000 - 0x00400000 (B flushed) -> 0x00800000.
- Issue at c and c+1, assert reset in c+2 -> no we_FP in c+3/c+4; all outputs 0 and inflight=0 after reset edge; new issue after deassert returns normally at +3.
- Inf: A=0x7F800000 FADD B=0x3F800000 -> 0x7F800000; A=0x3F800000 FSUB B=0x7F800000 -> 0xFF800000.
